uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive side of the UART link; the consumer of the transmitter's serial line. Recovers 8N1 frames (LSB first) from async rx.
//  Detects the start bit and samples each bit at its midpoint. Presents each byte over a valid/ready handshake.
//  Flags framing, parity and overrun errors. Sits between the board RX pin and the byte-level logic.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per bit (100 MHz / 9600 baud); must be >= 4
// PORTS
//  clk          in   1  100 MHz system clock
//  rst          in   1  synchronous, active-high reset
//  rx           in   1  serial input, asynchronous, idles high
//  rx_data      out  8  received byte, stable while rx_valid=1
//  rx_valid     out  1  byte available; held until accepted
//  rx_ready     in   1  consumer accepts: rx_valid & rx_ready in same cycle = transfer
//  rx_busy      out  1  high from start-bit detect until the frame ends (IDLE re-entered)
//  frame_err    out  1  1-cycle pulse: stop bit sampled low
//  parity_err   out  1  1-cycle pulse: parity mismatch (tied 0 when parity compiled out)
//  overrun_err  out  1  1-cycle pulse: frame completed while rx_valid still high
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, baud_cnt=0, bit_cnt=0, rx_data=0, rx_valid=0, rx_busy=0, all err=0, armed=0.
//  rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s; 2-cycle input latency.
//  armed: set when rx_s=1 in IDLE; cleared on start detect. No start accepted until the line has been seen high.
//  FSM:
//   IDLE: rx_s=0 & armed -> START, baud_cnt=0, rx_busy=1.
//   START: baud_cnt counts; at CLKS_PER_BIT/2-1 sample rx_s. 0 -> DATA, cnt=0. 1 -> false start, IDLE, no outputs.
//   DATA: at cnt=CLKS_PER_BIT-1 sample rx_s into shift_reg (shift right, new bit at [7]), cnt=0, bit_cnt++.
//         After bit_cnt=7 -> PARITY (macro on) or STOP; bit_cnt=0.
//   PARITY: at cnt=CLKS_PER_BIT-1 sample; mismatch latched internally -> STOP.
//   STOP: at cnt=CLKS_PER_BIT-1 sample rx_s, then ->IDLE, rx_busy=0, and exactly one outcome:
//     stop=0                   -> frame_err pulse; byte discarded; rx_valid/rx_data unchanged
//     stop=1, parity bad       -> parity_err pulse; byte discarded
//     stop=1, ok, rx_valid=1   -> overrun_err pulse; new byte dropped; held byte kept
//     stop=1, ok, rx_valid=0   -> next cycle rx_data=shift_reg, rx_valid=1
//   frame_err has priority over parity_err; each frame raises at most one error pulse.
//  Frame-complete and accept in the same cycle: accept first, so the new byte loads (no overrun).
//  rx_valid drops the cycle after a transfer. rx_ready ignored when rx_valid=0.
//  Stop decision falls mid stop bit, so back-to-back frames (next start immediately after stop) are received.
//  Line held low (break): one frame_err, then armed=0 blocks re-trigger until rx_s returns high.
//  Any state + rst: back to reset values next cycle; partial frame discarded, no pulses.
//  baud_cnt width: $clog2(CLKS_PER_BIT); never wraps (reset to 0 at each sample point).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame = start + 8 data + even parity + stop. Parity state present; parity_err active.
//  Not defined: 8N1; PARITY state absent; parity_err tied 0. Port list is identical in both builds.
// STRUCTURE
//  Shared package uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP); DEFAULT_CLKS_PER_BIT=10416; DATA_BITS=8.
//  Transmitter and receiver both use this package.
//  One sub-module: uart_sync2 (2-flop synchronizer, reset value 1); reusable for other async inputs.
//  Remainder (FSM, counters, output register) stays flat in uart_rx.
// TESTING  (bench uses CLKS_PER_BIT=16, drives rx from a bit-accurate serial model)
//  1. Send 0xA5 8N1, rx_ready=1 -> one rx_valid cycle, rx_data=0xA5; no error pulses.
//  2. rx_ready=0; send 0x3C then 0x81 back-to-back -> rx_valid held with 0x3C; overrun_err pulses once at 0x81 stop; data stays 0x3C.
//  3. Glitch: rx low for 4 clks only -> false start, return to IDLE, rx_valid=0, rx_busy falls within 10 clks.
//  4. 0x55 with stop bit driven 0 -> frame_err pulse, rx_valid stays 0; rx held low 5 bit times -> no further pulses until rx high, then 0x12 receives OK.
//  5. Parity build: 0x07 with odd (wrong) parity bit -> parity_err pulse, no rx_valid; 0x07 with parity bit=1 -> rx_data=0x07.
//  6. Assert rst mid-DATA of 0xFF -> all outputs reset next cycle; next frame 0x0F receives cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions used by both transmitter and receiver
//   DEFAULT_CLKS_PER_BIT : 100 MHz / 9600 baud
//   DATA_BITS            : payload bits per frame
//   uart_state_t         : frame FSM encodings
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
//   i_clk   : destination clock
//   i_rst   : synchronous active-high reset, both flops load RESET_VAL
//   i_async : asynchronous input
//   o_sync  : synchronized output, two cycles of latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits LSB first, optional even parity, one stop bit
//   Optional parity bit enabled by defining UART_RX_PARITY_EN.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   rx          : asynchronous serial input, idles high
//   rx_data     : received byte, stable while rx_valid=1
//   rx_valid    : byte available, held until accepted
//   rx_ready    : consumer accept (transfer when rx_valid & rx_ready)
//   rx_busy     : high from start-bit detect until IDLE is re-entered
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   parity_err  : 1-cycle pulse, parity mismatch (constant 0 without parity)
//   overrun_err : 1-cycle pulse, frame completed while rx_valid still high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_armed;
  logic                 r_frame_err;
  logic                 r_overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_armed       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      // Accept is resolved before frame completion so a same-cycle accept
      // frees the slot; a later r_valid <= 1 in this block overrides the drop.
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Start only after the line has been seen high, so a held-low
          // line (break) cannot retrigger frame after frame.
          if (!w_rx_s && r_armed) begin
            r_state    <= S_START;
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
            r_armed    <= 1'b0;
          end else if (w_rx_s) begin
            r_armed <= 1'b1;
          end
        end

        S_START: begin
          if (r_baud_cnt == HALF_LAST) begin
            r_baud_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end else begin
              // Line recovered before mid start bit: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_baud_cnt == FULL_LAST) begin
            r_baud_cnt <= '0;
            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_baud_cnt == FULL_LAST) begin
            r_baud_cnt <= '0;
            // Even parity: data bits plus parity bit must XOR to zero.
            r_par_bad  <= w_rx_s ^ (^r_shift);
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          // Decided mid stop bit, leaving half a bit in IDLE to re-arm
          // before a back-to-back start edge.
          if (r_baud_cnt == FULL_LAST) begin
            r_baud_cnt <= '0;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (r_par_bad) begin
              r_parity_err <= 1'b1;
`endif
            end else if (r_valid && !rx_ready) begin
              r_overrun_err <= 1'b1;
            end else begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign rx_busy     = r_busy;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (CLKS_PER_BIT=16)
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         n_xfer = 0;
  int         n_vcyc = 0;
  int         n_fe   = 0;
  int         n_pe   = 0;
  int         n_oe   = 0;
  logic [7:0] last_data = 8'h00;

  int s_xfer, s_vcyc, s_fe, s_pe, s_oe;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      n_xfer    <= n_xfer + 1;
      last_data <= rx_data;
    end
    if (rx_valid)    n_vcyc <= n_vcyc + 1;
    if (frame_err)   n_fe   <= n_fe + 1;
    if (parity_err)  n_pe   <= n_pe + 1;
    if (overrun_err) n_oe   <= n_oe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_xfer = n_xfer;
    s_vcyc = n_vcyc;
    s_fe   = n_fe;
    s_pe   = n_pe;
    s_oe   = n_oe;
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(^d);
`endif
    bit_time(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(par);
    bit_time(1'b1);
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_rx_data",  32'(rx_data),     32'h00);
    chk("reset_rx_valid", 32'(rx_valid),    32'h0);
    chk("reset_rx_busy",  32'(rx_busy),     32'h0);
    chk("reset_frame",    32'(frame_err),   32'h0);
    chk("reset_parity",   32'(parity_err),  32'h0);
    chk("reset_overrun",  32'(overrun_err), 32'h0);

    // 1: single clean frame
    @(negedge clk);
    rst = 1'b0;
    bit_time(1'b1);
    bit_time(1'b1);
    snap();
    send_frame(8'hA5, 1'b1);
    bit_time(1'b1);
    #1;
    chk("t1_xfer_count",  32'(n_xfer - s_xfer), 32'd1);
    chk("t1_data",        32'(last_data),       32'hA5);
    chk("t1_valid_cycles",32'(n_vcyc - s_vcyc), 32'd1);
    chk("t1_errors",      32'((n_fe - s_fe) + (n_pe - s_pe) + (n_oe - s_oe)), 32'd0);
    chk("t1_busy_idle",   32'(rx_busy),         32'h0);

    // 2: consumer stalled, back-to-back frames -> overrun on the second
    @(negedge clk);
    rx_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    bit_time(1'b1);
    #1;
    chk("t2_valid_held",  32'(rx_valid),        32'h1);
    chk("t2_data_held",   32'(rx_data),         32'h3C);
    chk("t2_overrun",     32'(n_oe - s_oe),     32'd1);
    chk("t2_no_frame",    32'(n_fe - s_fe),     32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t2_valid_drop",  32'(rx_valid),        32'h0);
    chk("t2_data_kept",   32'(rx_data),         32'h3C);

    // 3: 4-clock glitch is a false start
    @(negedge clk);
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t3_busy_rise",   32'(rx_busy),         32'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("t3_busy_fall",   32'(rx_busy),         32'h0);
    chk("t3_no_valid",    32'(n_vcyc - s_vcyc), 32'd0);
    chk("t3_no_errors",   32'((n_fe - s_fe) + (n_pe - s_pe) + (n_oe - s_oe)), 32'd0);

    // 4: bad stop bit then break, then recovery
    @(negedge clk);
    bit_time(1'b1);
    snap();
    send_frame(8'h55, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    #1;
    chk("t4_frame_once",  32'(n_fe - s_fe),     32'd1);
    chk("t4_no_valid",    32'(n_vcyc - s_vcyc), 32'd0);
    chk("t4_busy_break",  32'(rx_busy),         32'h0);
    chk("t4_no_other",    32'((n_pe - s_pe) + (n_oe - s_oe)), 32'd0);
    @(negedge clk);
    bit_time(1'b1);
    send_frame(8'h12, 1'b1);
    bit_time(1'b1);
    #1;
    chk("t4_recover_xfer",32'(n_xfer - s_xfer), 32'd1);
    chk("t4_recover_data",32'(last_data),       32'h12);
    chk("t4_frame_total", 32'(n_fe - s_fe),     32'd1);

    // 5: parity
`ifdef UART_RX_PARITY_EN
    @(negedge clk);
    snap();
    send_frame_par(8'h07, 1'b0);
    bit_time(1'b1);
    #1;
    chk("t5_parity_err",  32'(n_pe - s_pe),     32'd1);
    chk("t5_bad_no_xfer", 32'(n_xfer - s_xfer), 32'd0);
    chk("t5_bad_no_fe",   32'(n_fe - s_fe),     32'd0);
    @(negedge clk);
    send_frame_par(8'h07, 1'b1);
    bit_time(1'b1);
    #1;
    chk("t5_good_xfer",   32'(n_xfer - s_xfer), 32'd1);
    chk("t5_good_data",   32'(last_data),       32'h07);
    chk("t5_parity_total",32'(n_pe - s_pe),     32'd1);
`else
    #1;
    chk("t5_parity_tied", 32'(n_pe),            32'd0);
`endif

    // 6: reset mid-DATA of 0xFF, then a clean frame
    @(negedge clk);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    bit_time(1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_rst_data",    32'(rx_data),         32'h00);
    chk("t6_rst_valid",   32'(rx_valid),        32'h0);
    chk("t6_rst_busy",    32'(rx_busy),         32'h0);
    chk("t6_rst_errs",    32'({frame_err, parity_err, overrun_err}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    snap();
    for (int i = 0; i < 8; i++) bit_time(1'b1);
    send_frame(8'h0F, 1'b1);
    bit_time(1'b1);
    #1;
    chk("t6_after_xfer",  32'(n_xfer - s_xfer), 32'd1);
    chk("t6_after_data",  32'(last_data),       32'h0F);
    chk("t6_after_errs",  32'((n_fe - s_fe) + (n_pe - s_pe) + (n_oe - s_oe)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
